// File: rtl/vocab_pkg.sv
// Shared definitions for the vocabulary SRAM write/scan protocol.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package vocab_pkg;

    // Writer FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_TERM  = 2'd2,
        S_CLEAR = 2'd3
    } writer_state_t;

    // Word separator in the packed vocabulary; the matcher uses the same value
    localparam int NULL_CHAR = 0;

endpackage

// File: rtl/vocab_len.sv
// Counts leading non-null characters of a word, starting from char 0.
// Latency: combinational.
// Backpressure: none; pure function of the input word.
module vocab_len
    import vocab_pkg::*;
#(
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_W       = $clog2(WORD_LENGTH + 1)
) (
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    output logic [LEN_W-1:0]                  len
);

    // Scan from char 0 and stop counting at the first null; later chars are ignored
    always_comb begin
        logic stop;
        len  = '0;
        stop = 1'b0;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if (!stop) begin
                if (word[i*DATA_WIDTH +: DATA_WIDTH] != DATA_WIDTH'(NULL_CHAR)) begin
                    len = LEN_W'(i + 1);
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vocab_writer.sv
// Writes null-terminated words into the vocab SRAM from address 0 upward; also zero-fills on clear.
// Latency: accept edge E, chars at E+1..E+len, terminator at E+len+1, done the cycle after.
// Backpressure: word_ready only in IDLE and not full; words that do not fit are dropped (sticky overflow).
module vocab_writer
    import vocab_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              blocker_clk,
    input  logic                              rst_n,
    input  logic                              word_valid,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    output logic                              word_ready,
    input  logic                              clear,
    output logic                              sram_cs,
    output logic                              sram_we,
    output logic [ADDR_WIDTH-1:0]             sram_addr,
    output logic [DATA_WIDTH-1:0]             sram_din,
    output logic [ADDR_WIDTH:0]               wr_count,
    output logic                              full,
    output logic                              overflow,
    output logic                              done
);

    localparam int LEN_W = $clog2(WORD_LENGTH + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    writer_state_t                     state_q, state_d;
    logic [ADDR_WIDTH:0]               wr_count_q;
    logic                              overflow_q;
    logic                              done_q;
    logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q;
    logic [LEN_W-1:0]                  len_q;
    logic [LEN_W-1:0]                  idx_q;
    logic [ADDR_WIDTH-1:0]             clr_addr_q;

    logic [LEN_W-1:0]                  len_in;
    logic [ADDR_WIDTH:0]               space;
    logic                              fits;
    logic                              offer;
    logic [DATA_WIDTH-1:0]             cur_char;

    vocab_len #(
        .WORD_LENGTH (WORD_LENGTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .LEN_W       (LEN_W)
    ) u_len (
        .word (word),
        .len  (len_in)
    );

    // Free space and fit check: a word needs len chars plus its terminator
    assign space = DEPTH - wr_count_q;
    assign full  = space < (ADDR_WIDTH+1)'(2);
    assign fits  = (32'(len_in) + 32'd1) <= 32'(space);
    // A word is taken off the producer this edge (clear wins over a word)
    assign offer = (state_q == S_IDLE) && !clear && word_valid && !full;

    assign wr_count = wr_count_q;
    assign overflow = overflow_q;
    assign done     = done_q;

    // Select the character currently being written
    always_comb begin
        cur_char = '0;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if (idx_q == LEN_W'(i)) begin
                cur_char = word_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge blocker_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore SRAM/handshake outputs
    always_comb begin
        state_d    = state_q;
        word_ready = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_din   = '0;
        case (state_q)
            S_IDLE: begin
                word_ready = !full;
                if (clear) begin
                    state_d = S_CLEAR;
                end else if (offer && (len_in != '0) && fits) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                sram_cs   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = wr_count_q[ADDR_WIDTH-1:0];
                sram_din  = cur_char;
                if ((idx_q + LEN_W'(1)) == len_q) begin
                    state_d = S_TERM;
                end
            end
            S_TERM: begin
                sram_cs   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = wr_count_q[ADDR_WIDTH-1:0];
                sram_din  = DATA_WIDTH'(NULL_CHAR);
                state_d   = S_IDLE;
            end
            S_CLEAR: begin
                sram_cs   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = clr_addr_q;
                sram_din  = DATA_WIDTH'(NULL_CHAR);
                if (clr_addr_q == '1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: word latch, write pointer, clear pointer, overflow and done
    always_ff @(posedge blocker_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            word_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            clr_addr_q <= '0;
        end else begin
            done_q <= (state_q == S_TERM);
            case (state_q)
                S_IDLE: begin
                    if (offer && (len_in != '0)) begin
                        if (fits) begin
                            word_q <= word;
                            len_q  <= len_in;
                            idx_q  <= '0;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    wr_count_q <= wr_count_q + (ADDR_WIDTH+1)'(1);
                    idx_q      <= idx_q + LEN_W'(1);
                end
                S_TERM: begin
                    wr_count_q <= wr_count_q + (ADDR_WIDTH+1)'(1);
                end
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                    if (clr_addr_q == '1) begin
                        wr_count_q <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vocab_writer.md
# vocab_writer

Loads words into the vocabulary SRAM that the matcher later scans. It writes each word one character per cycle, followed by a 0x00 terminator, so the SRAM holds a packed null-separated vocabulary. It is the write side of the vocab SRAM protocol:
- a 0x00 byte ends a word;
- addresses are filled from 0 upward.

## Interface
Parameters:
- ADDR_WIDTH, 4, SRAM address width; depth D = 2^ADDR_WIDTH
- WORD_LENGTH, 3, maximum characters per word
- DATA_WIDTH, 8, bits per character

Ports:
- blocker_clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- word_valid  input  1  producer offers a word
- word  input  WORD_LENGTH*DATA_WIDTH  character i at bits [i*DATA_WIDTH +: DATA_WIDTH]; char 0 is written first
- word_ready  output  1  block can accept a word this cycle
- clear  input  1  request zero-fill of the whole SRAM
- sram_cs  output  1  SRAM chip select
- sram_we  output  1  SRAM write enable
- sram_addr  output  ADDR_WIDTH  SRAM address
- sram_din  output  DATA_WIDTH  SRAM write data
- wr_count  output  ADDR_WIDTH+1  next free address, range 0..D
- full  output  1  high when D - wr_count < 2 (cannot fit a 1-char word plus terminator)
- overflow  output  1  sticky; a word was dropped for lack of space
- done  output  1  one-cycle pulse after a word's terminator is written

## Operation
- FSM states: IDLE, WRITE, TERM, CLEAR.
- **IDLE**
  - word_ready = !full.
  - clear has priority over word_valid in the same cycle: go to CLEAR, and the word is not accepted.
- **Accept** (word_valid && word_ready at an edge):
  - Latch the word.
  - len = count of leading nonzero characters from char 0. Characters after the first 0x00 are ignored.
  - len == 0: word is dropped, stay in IDLE, no writes, no done, overflow unchanged.
  - len+1 > D - wr_count: word is dropped, overflow <= 1, stay in IDLE.
  - Otherwise go to WRITE with index i = 0.
- **WRITE** (one write per cycle)
  - sram_cs = sram_we = 1, sram_addr = wr_count[ADDR_WIDTH-1:0], sram_din = char i.
  - At the edge: wr_count++, i++. After char len-1, go to TERM.
- **TERM**
  - Write 0x00 at wr_count, then wr_count++.
  - Next state is IDLE with done = 1 for that one cycle.
- **CLEAR**
  - Write 0x00 to addresses 0..D-1, one per cycle, using a dedicated address counter.
  - After address D-1: wr_count <= 0, overflow <= 0, return to IDLE.
  - clear and word_valid are ignored during CLEAR.
- Outputs outside WRITE/TERM/CLEAR: sram_cs = sram_we = 0, sram_addr = 0, sram_din = 0.
- word_ready = 0 in every state except IDLE.
- wr_count never exceeds D. The fit check guarantees that no write wraps the address.

## Timing
- Reset values:
  - state IDLE, wr_count 0, overflow 0, done 0, word_ready 1
  - sram_cs 0, sram_we 0, sram_addr 0, sram_din 0
- Reset asserted mid-WRITE, mid-TERM or mid-CLEAR aborts immediately. SRAM contents already written are left as they are; no cleanup.
- Word accepted at edge E with length len:
  - chars are written at edges E+1..E+len;
  - the terminator is written at edge E+len+1;
  - done and word_ready are high in the cycle following E+len+1.
- Throughput: len+2 cycles per word including the accept cycle.
- A drop (empty word or no space) takes one cycle; word_ready stays high.
- CLEAR takes D cycles after the request edge; word_ready returns high in cycle D+1.
- sram_* outputs are Moore outputs decoded from registered state/counters. They are valid for the whole cycle, so the SRAM samples them on the next rising edge of blocker_clk.

## Structure
- Shared package (vocab_pkg):
  - writer state enum typedef;
  - NULL_CHAR = 0 constant, shared with the matcher-side logic.
- One sub-module: vocab_len, a combinational leading-nonzero character counter, parameterised by WORD_LENGTH and DATA_WIDTH, output width $clog2(WORD_LENGTH+1).
- Everything else lives in vocab_writer.

## Test plan
- Reset, then send "cat" (word = 24'h746163):
  - writes addr0 = 63, addr1 = 61, addr2 = 74, addr3 = 00;
  - wr_count = 4; done 5 cycles after accept.
- "hi" padded (24'h006968) followed immediately by "ab" (24'h006261):
  - addrs 0..5 = 68, 69, 00, 61, 62, 00; two done pulses; wr_count = 6.
- Word 24'h000000:
  - no SRAM writes, no done, word_ready high the next cycle, wr_count unchanged.
- Fill to wr_count = 14, then send a 3-char word:
  - dropped; overflow = 1; no writes.
  - A following 1-char word is accepted, wr_count = 16, full = 1, word_ready = 0.
- Assert clear and word_valid in the same IDLE cycle:
  - CLEAR wins and 16 zero writes follow;
  - then wr_count = 0, overflow = 0, and the word is accepted afterwards.
- Assert rst_n low during the second character write of "cat":
  - outputs go to reset values immediately; wr_count = 0; FSM in IDLE.
